// File: rtl/wam_game_core.sv
// Whack-a-mole game-control core: sequences idle/restart/ready/play/game-over
// and scores key hits against the active light in points, timed or lives mode.
module wam_game_core #(
  parameter int POS_W         = 4,
  parameter int SCORE_W       = 6,
  parameter int TICK_MAX      = 49_999_999,
  parameter int READY_SECS    = 5,
  parameter int GAME_SECS     = 60,
  parameter int LIVES         = 3,
  parameter int NORMAL_HITS   = 25,
  parameter int EXTENDED_HITS = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic [1:0]         mode,
  input  logic               extended,
  input  logic               light_on,
  input  logic               light_off,
  input  logic [POS_W-1:0]   light_pos,
  input  logic               key_valid,
  input  logic [POS_W-1:0]   key_pos,
  output logic [2:0]         state,
  output logic               clear,
  output logic               flick_enable,
  output logic [2:0]         ready_count,
  output logic [SCORE_W-1:0] time_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [2:0]         lives_left,
  output logic [SCORE_W-1:0] max_hits,
  output logic               hit,
  output logic               game_over
);

  // state     | meaning
  // S_IDLE    | waiting for the first play request
  // S_RESTART | one cycle: latch mode/limit, load counters
  // S_READY   | countdown before play, one step per tick
  // S_PLAY    | lights flicking, hits/misses scored
  // S_OVER    | game finished, counters frozen

  localparam int PW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_READY   = 3'd2,
    S_PLAY    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [SCORE_W-1:0] max_hits_q, max_hits_d;
  logic [2:0]         ready_count_q, ready_count_d;
  logic [SCORE_W-1:0] time_left_q, time_left_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] misses_q, misses_d;
  logic [2:0]         lives_left_q, lives_left_d;
  logic [SCORE_W-1:0] light_cnt_q, light_cnt_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               active_q, active_d;
  logic               hit_taken_q, hit_taken_d;
  logic               hit_q, hit_d;

  logic tick, play_live, hit_now, miss_now, mode_points;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    max_hits_d    = max_hits_q;
    ready_count_d = ready_count_q;
    time_left_d   = time_left_q;
    score_d       = score_q;
    misses_d      = misses_q;
    lives_left_d  = lives_left_q;
    light_cnt_d   = light_cnt_q;
    presc_d       = presc_q;
    active_d      = active_q;
    hit_taken_d   = hit_taken_q;
    hit_d         = 1'b0;

    tick        = (presc_q == PW'(TICK_MAX));
    mode_points = (mode_q == 2'd0) || (mode_q == 2'd3);
    play_live   = (state_q == S_PLAY) && !play;
    hit_now     = play_live && key_valid && active_q && !hit_taken_q && (key_pos == light_pos);
    // A hit landing on the expiry cycle wins, so that light is not also a miss.
    miss_now    = play_live && light_off && active_q && !hit_taken_q && !hit_now;

    case (state_q)
      S_IDLE: begin
        if (play) state_d = S_RESTART;
      end
      S_RESTART: begin
        mode_d        = mode;
        max_hits_d    = extended ? SCORE_W'(EXTENDED_HITS) : SCORE_W'(NORMAL_HITS);
        ready_count_d = 3'(READY_SECS);
        time_left_d   = SCORE_W'(GAME_SECS);
        lives_left_d  = 3'(LIVES);
        score_d       = '0;
        misses_d      = '0;
        light_cnt_d   = '0;
        presc_d       = '0;
        active_d      = 1'b0;
        hit_taken_d   = 1'b0;
        state_d       = S_READY;
      end
      S_READY: begin
        if (play) begin
          state_d = S_RESTART;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (ready_count_q <= 3'd1) begin
              ready_count_d = 3'd0;
              presc_d       = '0;
              state_d       = S_PLAY;
            end else begin
              ready_count_d = ready_count_q - 3'd1;
            end
          end
        end
      end
      S_PLAY: begin
        if (play) begin
          state_d = S_RESTART;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (mode_q == 2'd1 && tick && time_left_q != '0)
            time_left_d = time_left_q - 1'b1;
          if (hit_now) begin
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
            hit_d       = 1'b1;
            hit_taken_d = 1'b1;
          end
          if (miss_now) begin
            if (misses_q != {SCORE_W{1'b1}}) misses_d = misses_q + 1'b1;
            if (mode_q == 2'd2 && lives_left_q != 3'd0) lives_left_d = lives_left_q - 3'd1;
          end
          // Old light is resolved before a same-cycle new light is armed.
          if (light_off) active_d = 1'b0;
          if (light_on) begin
            active_d    = 1'b1;
            hit_taken_d = 1'b0;
            if (light_cnt_q != max_hits_q) light_cnt_d = light_cnt_q + 1'b1;
          end
          if (mode_q == 2'd1 && time_left_q == '0)
            state_d = S_OVER;
          if (mode_q == 2'd2 && lives_left_q == 3'd0)
            state_d = S_OVER;
          if (mode_points && light_cnt_q == max_hits_q && (hit_now || (light_off && active_q)))
            state_d = S_OVER;
        end
      end
      S_OVER: begin
        if (play) state_d = S_RESTART;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'd0;
      max_hits_q    <= '0;
      ready_count_q <= 3'd0;
      time_left_q   <= '0;
      score_q       <= '0;
      misses_q      <= '0;
      lives_left_q  <= 3'd0;
      light_cnt_q   <= '0;
      presc_q       <= '0;
      active_q      <= 1'b0;
      hit_taken_q   <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      max_hits_q    <= max_hits_d;
      ready_count_q <= ready_count_d;
      time_left_q   <= time_left_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      lives_left_q  <= lives_left_d;
      light_cnt_q   <= light_cnt_d;
      presc_q       <= presc_d;
      active_q      <= active_d;
      hit_taken_q   <= hit_taken_d;
      hit_q         <= hit_d;
    end
  end

  assign state        = state_q;
  assign clear        = (state_q == S_RESTART);
  assign flick_enable = (state_q == S_PLAY);
  assign game_over    = (state_q == S_OVER);
  assign ready_count  = ready_count_q;
  assign time_left    = time_left_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign lives_left   = lives_left_q;
  assign max_hits     = max_hits_q;
  assign hit          = hit_q;

endmodule

// File: tb/tb_wam_game_core.sv
// Directed bench for wam_game_core with small timing parameters.
module tb_wam_game_core;
  localparam int POS_W = 4;
  localparam int SW    = 6;

  logic             clk, reset, play, extended, light_on, light_off, key_valid;
  logic [1:0]       mode;
  logic [POS_W-1:0] light_pos, key_pos;
  logic [2:0]       state, ready_count, lives_left;
  logic             clear, flick_enable, hit, game_over;
  logic [SW-1:0]    time_left, score, misses, max_hits;

  int vectors = 0;
  int miscompares = 0;

  wam_game_core #(
    .POS_W(POS_W), .SCORE_W(SW), .TICK_MAX(3), .READY_SECS(3), .GAME_SECS(4),
    .LIVES(2), .NORMAL_HITS(3), .EXTENDED_HITS(5)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .mode(mode), .extended(extended),
    .light_on(light_on), .light_off(light_off), .light_pos(light_pos),
    .key_valid(key_valid), .key_pos(key_pos), .state(state), .clear(clear),
    .flick_enable(flick_enable), .ready_count(ready_count), .time_left(time_left),
    .score(score), .misses(misses), .lives_left(lives_left), .max_hits(max_hits),
    .hit(hit), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  // Restart and run through the ready countdown, bounded.
  task automatic start_game(input logic [1:0] m);
    int n;
    mode = m;
    pulse_play();
    chk("restart_state", state, 3'd1);
    n = 0;
    while (state != 3'd3 && n < 40) begin
      step();
      n++;
    end
    chk("reach_play", state, 3'd3);
  endtask

  task automatic light(input logic [POS_W-1:0] pos);
    light_on = 1'b1; light_pos = pos;
    step();
    light_on = 1'b0;
  endtask

  task automatic key(input logic [POS_W-1:0] pos);
    key_valid = 1'b1; key_pos = pos;
    step();
    key_valid = 1'b0;
  endtask

  task automatic expire();
    light_off = 1'b1;
    step();
    light_off = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; mode = 2'd0; extended = 1'b0;
    light_on = 1'b0; light_off = 1'b0; light_pos = '0; key_valid = 1'b0; key_pos = '0;
    repeat (2) step();
    chk("rst_state", state, 3'd0);
    chk("rst_ready", ready_count, 3'd0);
    chk("rst_score", score, 6'd0);
    chk("rst_maxhits", max_hits, 6'd0);
    chk("rst_flags", {clear, flick_enable, game_over, hit}, 4'b0000);
    reset = 1'b0;
    step();
    chk("idle_hold", state, 3'd0);

    // 1: restart then ready countdown, 12 READY cycles
    pulse_play();
    chk("t1_restart", state, 3'd1);
    chk("t1_clear", clear, 1'b1);
    step();
    chk("t1_lives", lives_left, 3'd2);
    chk("t1_time", time_left, 6'd4);
    chk("t1_maxhits", max_hits, 6'd3);
    for (int k = 0; k < 12; k++) begin
      chk("t1_ready_state", state, 3'd2);
      chk("t1_ready_count", ready_count, 3'(3 - k / 4));
      step();
    end
    chk("t1_play", state, 3'd3);
    chk("t1_flick", flick_enable, 1'b1);
    chk("t1_ready_zero", ready_count, 3'd0);

    // 2: points mode, three correct hits
    light(4'd5);
    key(4'd5);
    chk("t2_score1", score, 6'd1);
    chk("t2_hit1", hit, 1'b1);
    step();
    chk("t2_hit1_end", hit, 1'b0);
    light(4'd6);
    key(4'd6);
    chk("t2_score2", score, 6'd2);
    chk("t2_hit2", hit, 1'b1);
    light(4'd7);
    chk("t2_still_play", state, 3'd3);
    key(4'd7);
    chk("t2_score3", score, 6'd3);
    chk("t2_hit3", hit, 1'b1);
    chk("t2_over", state, 3'd4);
    chk("t2_gameover", game_over, 1'b1);
    chk("t2_misses", misses, 6'd0);

    // 3: timed mode, no lights
    start_game(2'd1);
    for (int k = 0; k <= 16; k++) begin
      chk("t3_time", time_left, 6'(4 - k / 4));
      chk("t3_state", state, 3'd3);
      step();
    end
    chk("t3_over", state, 3'd4);
    step();
    step();
    chk("t3_hold_time", time_left, 6'd0);
    chk("t3_hold_state", state, 3'd4);

    // 4: lives mode, two unhit lights expire
    start_game(2'd2);
    chk("t4_lives0", lives_left, 3'd2);
    light(4'd1);
    expire();
    chk("t4_miss1", misses, 6'd1);
    chk("t4_lives1", lives_left, 3'd1);
    light(4'd2);
    expire();
    chk("t4_miss2", misses, 6'd2);
    chk("t4_lives2", lives_left, 3'd0);
    step();
    chk("t4_over", state, 3'd4);
    light(4'd3);
    expire();
    chk("t4_ignored_miss", misses, 6'd2);
    chk("t4_ignored_lives", lives_left, 3'd0);

    // 5: double press, wrong key, hit on expiry cycle
    start_game(2'd0);
    light(4'd7);
    key(4'd7);
    chk("t5_first", score, 6'd1);
    key(4'd7);
    chk("t5_repeat", score, 6'd1);
    chk("t5_repeat_hit", hit, 1'b0);
    key(4'd3);
    chk("t5_wrong", score, 6'd1);
    expire();
    chk("t5_no_miss", misses, 6'd0);
    light(4'd9);
    key_valid = 1'b1; key_pos = 4'd9; light_off = 1'b1;
    step();
    key_valid = 1'b0; light_off = 1'b0;
    chk("t5_hit_off_score", score, 6'd2);
    chk("t5_hit_off_miss", misses, 6'd0);
    chk("t5_hit_off_pulse", hit, 1'b1);
    chk("t5_still_play", state, 3'd3);

    // 6: play mid-game re-latches mode/extended; reset mid-READY
    extended = 1'b1;
    start_game(2'd1);
    chk("t6_score_cleared", score, 6'd0);
    chk("t6_maxhits", max_hits, 6'd5);
    repeat (4) step();
    chk("t6_timed_relatched", time_left, 6'd3);
    pulse_play();
    chk("t6_restart2", state, 3'd1);
    repeat (3) step();
    chk("t6_in_ready", state, 3'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_state", state, 3'd0);
    chk("t6_rst_counts", {ready_count, time_left, lives_left, max_hits}, 21'd0);
    chk("t6_rst_flags", {clear, flick_enable, game_over, hit}, 4'b0000);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wam_game_core.md
Name: wam_game_core

Overview:
Parameterised game-control core for the whack-a-mole design, successor to the hard-wired top-level game FSM. It sequences idle, restart, ready countdown, play and game over, and scores key hits against the active light. It adds three things the earlier FSM lacked:
- a working lives mode;
- single-hit-per-light scoring, with miss counting;
- a latched game mode.
It sits between light_controller / keypad_controller and the HEX display decoders.

Parameters:
POS_W, 4, width of light_pos / key_pos
SCORE_W, 6, width of score, misses, light count, time_left
TICK_MAX, 49_999_999, clk cycles per 1 s tick minus 1
READY_SECS, 5, ready countdown length in seconds (1..7)
GAME_SECS, 60, timed-mode duration in seconds
LIVES, 3, starting lives in lives mode (1..7)
NORMAL_HITS, 25, lights per game with extended=0
EXTENDED_HITS, 50, lights per game with extended=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
play  in  1  single-cycle start/restart request
mode  in  2  0=points, 1=timed, 2=lives, 3=treated as points
extended  in  1  selects EXTENDED_HITS
light_on  in  1  pulse: new light lit this cycle, position on light_pos
light_off  in  1  pulse: current light expired this cycle
light_pos  in  POS_W  position of current light
key_valid  in  1  pulse: debounced key press
key_pos  in  POS_W  pressed key position
state  out  3  0=IDLE, 1=RESTART, 2=READY, 3=PLAY, 4=GAME_OVER
clear  out  1  high in RESTART only; clears downstream datapath
flick_enable  out  1  high in PLAY only
ready_count  out  3  countdown value shown during READY
time_left  out  SCORE_W  seconds remaining (timed mode)
score  out  SCORE_W  hits
misses  out  SCORE_W  unhit expired lights
lives_left  out  3  remaining lives (lives mode)
max_hits  out  SCORE_W  latched light limit
hit  out  1  one-cycle pulse on a scored hit
game_over  out  1  high in GAME_OVER

Behaviour:
Reset values:
- state=IDLE; ready_count, time_left, score, misses, lives_left, max_hits, hit = 0.
- clear, flick_enable, game_over = 0.
- The tick prescaler and the light-tracking flags are also cleared.

State transitions:
- IDLE: play goes to RESTART.
- RESTART (exactly 1 cycle):
  - latch mode and max_hits (NORMAL_HITS or EXTENDED_HITS from extended);
  - ready_count=READY_SECS; time_left=GAME_SECS; lives_left=LIVES;
  - score=0; misses=0; light count=0; prescaler=0;
  - then go to READY.
- READY:
  - the prescaler counts 0..TICK_MAX, giving a tick on TICK_MAX that wraps to 0;
  - each tick decrements ready_count;
  - a tick while ready_count==1 sets ready_count=0, moves to PLAY, and zeroes the prescaler.
  - Latency from RESTART to PLAY = READY_SECS*(TICK_MAX+1) cycles.
- PLAY: flick_enable=1.
  - Timed mode: each tick decrements time_left. A tick at time_left==1 sets time_left=0 and goes to GAME_OVER next cycle.
  - Points mode: go to GAME_OVER once light count==max_hits and that light is resolved (hit or off).
  - Lives mode: go to GAME_OVER when lives_left reaches 0.
- GAME_OVER: all counters hold; play goes to RESTART.
- play in READY or PLAY goes to RESTART, with highest priority over every other event in that cycle.
- mode/extended changes outside RESTART are ignored.

Hit and miss rules (PLAY only):
- light_on sets the active flag, clears the hit_taken flag, and increments light count (saturating at max_hits).
- A hit requires key_valid, active flag set, hit_taken clear, and key_pos==light_pos. On a hit:
  - score+1, saturating at all-ones;
  - hit pulses 1 cycle later (registered);
  - hit_taken is set.
- Further presses on the same light score nothing.
- A wrong key has no effect.
- light_off with an active, unhit light: misses+1 (saturating). In lives mode, lives_left-1, saturating at 0.
- light_off clears the active flag.

Simultaneous events:
- key hit and light_off in the same cycle: the hit counts and there is no miss.
- light_off and light_on in the same cycle: resolve the old light first, then arm the new one.
- Events arriving outside PLAY are ignored.

Asynchronous reset mid-game returns to IDLE with all reset values immediately.

Test Plan:
Use TICK_MAX=3, READY_SECS=3, GAME_SECS=4, LIVES=2, NORMAL_HITS=3.
1. Reset, then play pulse -> state goes 1 then 2; ready_count 3,2,1 each 4 cycles apart; PLAY entered 12 cycles after RESTART.
2. Points mode, 3 lights each hit with the correct key -> score=3, three hit pulses, GAME_OVER after the 3rd hit; misses=0.
3. Timed mode, no lights -> time_left 4,3,2,1,0 at 4-cycle steps; GAME_OVER on the cycle after reaching 0.
4. Lives mode, two lights expire unhit -> misses=2, lives_left 2,1,0, GAME_OVER; a third light_on is ignored.
5. Key pressed twice on one light, plus a wrong key -> score=1 only. A hit in the same cycle as light_off -> score+1, misses unchanged.
6. play pulse mid-PLAY with score=2 -> RESTART, score=0, mode re-latched. Reset asserted mid-READY -> IDLE, all outputs 0.
